// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared helpers and types for the pipelined add/subtract unit
package pipelined_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int chunk_of(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic bit split_ok(input int width, input int stages);
      return stages > 0 && width % stages == 0;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand and result valid/ready channels of the adder
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_adder_stage.sv
// pipelined_adder_stage: one registered CHUNK-wide carry slice with its own valid bit
module pipelined_adder_stage #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             v_in,
   input  logic             nxt,
   output logic             ld,
   output logic             v,
   input  logic [WIDTH-1:0] p_in,
   input  logic [WIDTH-1:0] x_in,
   input  logic             c_in,
   input  logic [1:0]       m_in,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] x,
   output logic             c,
   output logic [1:0]       m
);
   // p: unconsumed a bits shifted down, finished sum chunks entering from the top
   // x: unconsumed bx bits shifted down; m: {a_msb, bx_msb} for the overflow flag
   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] x;
      logic             c;
      logic [1:0]       m;
   } stage_t;

   stage_t         r, nx;
   logic [CHUNK:0] t;

   assign ld = !v || nxt;
   assign t  = {1'b0, p_in[CHUNK-1:0]} + {1'b0, x_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
   assign nx = '{
      p: (p_in >> CHUNK) | (WIDTH'(t[CHUNK-1:0]) << (WIDTH - CHUNK)),
      x: x_in >> CHUNK,
      c: t[CHUNK],
      m: m_in
   };
   assign p = r.p;
   assign x = r.x;
   assign c = r.c;
   assign m = r.m;

   // valid bit follows upstream whenever this slot is free or being drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) v <= 1'b0;
      else if (ld) v <= v_in;
   end

   // data captured only for a real beat so idle cycles leave the slice quiet
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r <= '0;
      else if (ld && v_in) r <= nx;
   end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked carry pipeline add/sub with valid/ready and bubble collapse
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic              clk,
   input logic              rst,
   pipelined_adder_if.slave bus
);
   localparam int CHUNK = chunk_of(WIDTH, STAGES);

   if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
      $error("pipelined_adder: WIDTH must be a multiple of STAGES");
   end

   logic [STAGES:0] v, ld, c;
   logic [WIDTH-1:0] p [STAGES+1];
   logic [WIDTH-1:0] x [STAGES+1];
   logic [1:0]       m [STAGES+1];
   logic             unused_skew;

   assign v[0]       = bus.in_valid;
   assign p[0]       = bus.a;
   assign x[0]       = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
   assign c[0]       = bus.cin ^ bus.sub;
   assign m[0]       = {bus.a[WIDTH-1], x[0][WIDTH-1]};
   assign ld[STAGES] = bus.out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipelined_adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_stage (
         .clk  (clk),
         .rst  (rst),
         .v_in (v[k]),
         .nxt  (ld[k+1]),
         .ld   (ld[k]),
         .v    (v[k+1]),
         .p_in (p[k]),
         .x_in (x[k]),
         .c_in (c[k]),
         .m_in (m[k]),
         .p    (p[k+1]),
         .x    (x[k+1]),
         .c    (c[k+1]),
         .m    (m[k+1])
      );
   end

   // every bx bit is consumed by the last slice; what is left is all zero
   assign unused_skew   = ^x[STAGES];
   assign bus.in_ready  = ld[0];
   assign bus.out_valid = v[STAGES];
   assign bus.sum       = p[STAGES];
   assign bus.cout      = c[STAGES];
   assign bus.ovf       = (m[STAGES][1] == m[STAGES][0]) && (p[STAGES][WIDTH-1] != m[STAGES][1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of three adder configurations
module tb_pipelined_adder;
   localparam int N = 10000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(16)) i4 ();
   pipelined_adder_if #(.WIDTH(16)) i1 ();
   pipelined_adder_if #(.WIDTH(32)) i8 ();

   pipelined_adder #(.WIDTH(16), .STAGES(4)) d4 (.clk(clk), .rst(rst), .bus(i4));
   pipelined_adder #(.WIDTH(16), .STAGES(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
   pipelined_adder #(.WIDTH(32), .STAGES(8)) d8 (.clk(clk), .rst(rst), .bus(i8));

   logic [2:0]  iv, ordy, ir, ov, co, of;
   logic [31:0] va, vb;
   logic        vcin, vsub;
   logic [31:0] sm [3];
   int          wd [3] = '{16, 16, 32};

   assign i4.in_valid = iv[0];  assign i4.out_ready = ordy[0];
   assign i1.in_valid = iv[1];  assign i1.out_ready = ordy[1];
   assign i8.in_valid = iv[2];  assign i8.out_ready = ordy[2];
   assign i4.a = va[15:0];  assign i4.b = vb[15:0];  assign i4.cin = vcin;  assign i4.sub = vsub;
   assign i1.a = va[15:0];  assign i1.b = vb[15:0];  assign i1.cin = vcin;  assign i1.sub = vsub;
   assign i8.a = va;        assign i8.b = vb;        assign i8.cin = vcin;  assign i8.sub = vsub;
   assign ir = {i8.in_ready, i1.in_ready, i4.in_ready};
   assign ov = {i8.out_valid, i1.out_valid, i4.out_valid};
   assign co = {i8.cout, i1.cout, i4.cout};
   assign of = {i8.ovf, i1.ovf, i4.ovf};
   assign sm[0] = {16'h0, i4.sum};
   assign sm[1] = {16'h0, i1.sum};
   assign sm[2] = i8.sum;

   int          tests = 0;
   int          fails = 0;
   logic [33:0] fq [3][64];
   int          wp [3] = '{0, 0, 0};
   int          rp [3] = '{0, 0, 0};

   // reference: plain integer arithmetic, signed range check for overflow
   function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      longint msk = (longint'(1) << w) - 1;
      longint hlf = longint'(1) << (w - 1);
      longint ci  = cin ? 1 : 0;
      longint ua  = longint'(a) & msk;
      longint ub  = longint'(b) & msk;
      longint sa  = (ua >= hlf) ? ua - (msk + 1) : ua;
      longint sb  = (ub >= hlf) ? ub - (msk + 1) : ub;
      longint r   = sub ? ua - ub - ci : ua + ub + ci;
      longint sr  = sub ? sa - sb - ci : sa + sb + ci;
      logic   c   = sub ? (r >= 0) : (r > msk);
      logic   o   = (sr < -hlf) || (sr >= hlf);
      return {o, c, 32'(r & msk)};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_8000;
         5: return 32'h0000_7FFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      iv = '0; ordy = '0; va = '0; vb = '0; vcin = 1'b0; vsub = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         tests++; if (ov[d] !== 1'b0) begin fails++; $display("FAIL reset_out_valid dut%0d got %b exp 0", d, ov[d]); end
         tests++; if (sm[d] !== 32'h0) begin fails++; $display("FAIL reset_sum dut%0d got %h exp 0", d, sm[d]); end
         tests++; if (co[d] !== 1'b0) begin fails++; $display("FAIL reset_cout dut%0d got %b exp 0", d, co[d]); end
         tests++; if (of[d] !== 1'b0) begin fails++; $display("FAIL reset_ovf dut%0d got %b exp 0", d, of[d]); end
         tests++; if (ir[d] !== 1'b1) begin fails++; $display("FAIL reset_in_ready dut%0d got %b exp 1", d, ir[d]); end
      end
   endtask

   task automatic test_directed();
      logic [15:0] ta [6] = '{16'h0001, 16'h0003, 16'hFFFF, 16'h3FFF, 16'h0005, 16'h8000};
      logic [15:0] tb [6] = '{16'h0002, 16'h0004, 16'h0001, 16'h7FFF, 16'h0007, 16'h0001};
      logic [5:0]  tc = 6'b000110;
      logic [5:0]  tsb = 6'b110000;
      logic [15:0] ts [6] = '{16'h0003, 16'h0008, 16'h0001, 16'hBFFE, 16'hFFFE, 16'h7FFF};
      logic [5:0]  tco = 6'b100100;
      logic [5:0]  tov = 6'b101000;
      int lat;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         va = {16'h0, ta[i]}; vb = {16'h0, tb[i]}; vcin = tc[i]; vsub = tsb[i];
         iv[0] = 1'b1; ordy[0] = 1'b1;
         #1;
         tests++; if (ir[0] !== 1'b1) begin fails++; $display("FAIL dir_in_ready vec%0d got %b exp 1", i, ir[0]); end
         @(negedge clk);
         iv[0] = 1'b0;
         lat = 1;
         while (ov[0] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         tests++; if (lat != 4) begin fails++; $display("FAIL dir_latency vec%0d got %0d exp 4", i, lat); end
         tests++;
         if ({of[0], co[0], sm[0][15:0]} !== {tov[i], tco[i], ts[i]}) begin
            fails++;
            $display("FAIL dir_result vec%0d got ovf=%b cout=%b sum=%h exp ovf=%b cout=%b sum=%h",
                     i, of[0], co[0], sm[0][15:0], tov[i], tco[i], ts[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acc = 0, got = 0, first = -1, last = -1;
      logic [33:0] e;
      ordy[0] = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         iv[0] = acc < 8; va = pick(); vb = pick(); vcin = 1'($urandom); vsub = 1'($urandom);
         #1;
         if (iv[0]) begin
            tests++; if (ir[0] !== 1'b1) begin fails++; $display("FAIL b2b_in_ready cyc%0d got %b exp 1", cyc, ir[0]); end
         end
         if (ov[0]) begin
            tests++;
            if (rp[0] == wp[0]) begin fails++; $display("FAIL b2b_spurious cyc%0d got beat exp none", cyc); end
            else begin
               e = fq[0][rp[0] % 64]; rp[0]++;
               if ({of[0], co[0], sm[0]} !== e) begin fails++; $display("FAIL b2b_result cyc%0d got %h exp %h", cyc, {of[0], co[0], sm[0]}, e); end
            end
            got++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (iv[0] && ir[0]) begin fq[0][wp[0] % 64] = model(16, va, vb, vcin, vsub); wp[0]++; acc++; end
      end
      tests++; if (got != 8) begin fails++; $display("FAIL b2b_count got %0d exp 8", got); end
      tests++; if (first != 4) begin fails++; $display("FAIL b2b_first got %0d exp 4", first); end
      tests++; if (last - first != 7) begin fails++; $display("FAIL b2b_span got %0d exp 7", last - first); end
      ordy[0] = 1'b0; acc = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         iv[0] = 1'b1; va = pick(); vb = pick(); vcin = 1'($urandom); vsub = 1'($urandom);
         #1;
         if (ir[0]) begin fq[0][wp[0] % 64] = model(16, va, vb, vcin, vsub); wp[0]++; acc++; end
      end
      tests++; if (acc != 4) begin fails++; $display("FAIL stall_accepts got %0d exp 4", acc); end
      tests++; if (ir[0] !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %b exp 0", ir[0]); end
      tests++; if (ov[0] !== 1'b1) begin fails++; $display("FAIL stall_out_valid got %b exp 1", ov[0]); end
      @(negedge clk);
      iv[0] = 1'b0; ordy[0] = 1'b1;
      for (int cyc = 0; cyc < 10 && rp[0] != wp[0]; cyc++) begin
         #1;
         if (ov[0]) begin
            e = fq[0][rp[0] % 64]; rp[0]++;
            tests++; if ({of[0], co[0], sm[0]} !== e) begin fails++; $display("FAIL drain_result got %h exp %h", {of[0], co[0], sm[0]}, e); end
         end
         @(negedge clk);
      end
      tests++; if (rp[0] != wp[0]) begin fails++; $display("FAIL drain_left got %0d exp 0", wp[0] - rp[0]); end
   endtask

   task automatic test_reset_flight();
      ordy = '0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         iv = 3'b111; va = pick(); vb = pick(); vcin = 1'($urandom); vsub = 1'($urandom);
      end
      @(negedge clk);
      iv = '0;
      repeat (2) @(negedge clk);
      tests++; if (ov[0] !== 1'b1) begin fails++; $display("FAIL flight_loaded got %b exp 1", ov[0]); end
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         tests++; if (ov[d] !== 1'b0) begin fails++; $display("FAIL flight_out_valid dut%0d got %b exp 0", d, ov[d]); end
         tests++; if ({of[d], co[d], sm[d]} !== 34'h0) begin fails++; $display("FAIL flight_outputs dut%0d got %h exp 0", d, {of[d], co[d], sm[d]}); end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) rp[d] = wp[d];
      ordy = 3'b111;
      #1;
      tests++; if (ir !== 3'b111) begin fails++; $display("FAIL flight_in_ready got %b exp 111", ir); end
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk); #1;
         tests++; if (ov !== 3'b000) begin fails++; $display("FAIL flight_stale cyc%0d got %b exp 000", cyc, ov); end
      end
   endtask

   task automatic test_random();
      int          acc [3] = '{0, 0, 0};
      logic [2:0]  held = '0;
      logic [33:0] prev [3];
      logic [33:0] e;
      for (int cyc = 0; cyc < 60000; cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            iv[d]   = acc[d] < N && $urandom_range(0, 9) < 7;
            ordy[d] = $urandom_range(0, 9) < 7;
         end
         va = pick(); vb = pick(); vcin = 1'($urandom); vsub = 1'($urandom);
         #1;
         for (int d = 0; d < 3; d++) begin
            if (held[d]) begin
               tests++;
               if ({ov[d], of[d], co[d], sm[d][31:1]} !== {1'b1, prev[d][33:1]} || sm[d][0] !== prev[d][0]) begin
                  fails++; $display("FAIL rnd_stall_stable dut%0d got %h exp %h", d, {of[d], co[d], sm[d]}, prev[d]);
               end
            end
            if (ov[d] && ordy[d]) begin
               tests++;
               if (rp[d] == wp[d]) begin fails++; $display("FAIL rnd_spurious dut%0d got beat exp none", d); end
               else begin
                  e = fq[d][rp[d] % 64]; rp[d]++;
                  if ({of[d], co[d], sm[d]} !== e) begin fails++; $display("FAIL rnd_result dut%0d got %h exp %h", d, {of[d], co[d], sm[d]}, e); end
               end
            end
            if (iv[d] && ir[d]) begin fq[d][wp[d] % 64] = model(wd[d], va, vb, vcin, vsub); wp[d]++; acc[d]++; end
            held[d] = ov[d] && !ordy[d];
            prev[d] = {of[d], co[d], sm[d]};
         end
         if (acc[0] == N && acc[1] == N && acc[2] == N && rp[0] == wp[0] && rp[1] == wp[1] && rp[2] == wp[2]) break;
      end
      iv = '0;
      for (int d = 0; d < 3; d++) begin
         tests++;
         if (acc[d] != N || rp[d] != wp[d]) begin
            fails++; $display("FAIL rnd_complete dut%0d got acc=%0d pending=%0d exp acc=%0d pending=0", d, acc[d], wp[d] - rp[d], N);
         end
      end
   endtask

   initial begin
      rst = 1'b1; iv = '0; ordy = '0; va = '0; vb = '0; vcin = 1'b0; vsub = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_flight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
